// File: rtl/pla_eval_pkg.sv
// Shared types and the cube match rule for the sequential sum-of-products evaluator.
package pla_eval_pkg;

  localparam int MAX_IN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Callers zero-extend to MAX_IN; padding bits carry care=0 so they never block a match.
  function automatic logic cube_match(input logic [MAX_IN-1:0] x,
                                      input logic [MAX_IN-1:0] care,
                                      input logic [MAX_IN-1:0] val);
    return ((x ^ val) & care) == '0;
  endfunction

endpackage

// File: rtl/pla_cube_table.sv
// Cube register file: synchronous write, combinational read, only the valid bits are reset.
module pla_cube_table #(
  parameter int N_IN    = 21,
  parameter int N_OUT   = 1,
  parameter int N_CUBES = 64,
  parameter int AW      = $clog2(N_CUBES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic              wr_en,
  input  logic [N_IN-1:0]   wr_care,
  input  logic [N_IN-1:0]   wr_val,
  input  logic [N_OUT-1:0]  wr_out,
  input  logic [AW-1:0]     raddr,
  output logic              rd_en,
  output logic [N_IN-1:0]   rd_care,
  output logic [N_IN-1:0]   rd_val,
  output logic [N_OUT-1:0]  rd_out
);

  logic [N_CUBES-1:0] en_q;
  logic [N_IN-1:0]    care_q [N_CUBES];
  logic [N_IN-1:0]    val_q  [N_CUBES];
  logic [N_OUT-1:0]   out_q  [N_CUBES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
    end else if (we) begin
      en_q[waddr] <= wr_en;
    end
  end

  // Payload is meaningless while its valid bit is clear, so it needs no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      care_q[waddr] <= wr_care;
      val_q[waddr]  <= wr_val;
      out_q[waddr]  <= wr_out;
    end
  end

  assign rd_en   = en_q[raddr];
  assign rd_care = care_q[raddr];
  assign rd_val  = val_q[raddr];
  assign rd_out  = out_q[raddr];

endmodule

// File: rtl/pla_seq_evaluator.sv
// Programmable sum-of-products evaluator: scans one cube per clock, early-exits when all outputs are set.
module pla_seq_evaluator
  import pla_eval_pkg::*;
#(
  parameter int               N_IN    = 21,
  parameter int               N_OUT   = 1,
  parameter int               N_CUBES = 64,
  parameter logic [N_OUT-1:0] OUT_INV = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(N_CUBES)-1:0] cfg_addr,
  input  logic                       cfg_en,
  input  logic [N_IN-1:0]            cfg_care,
  input  logic [N_IN-1:0]            cfg_val,
  input  logic [N_OUT-1:0]           cfg_out,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_y,
  output logic                       busy
);

  localparam int            AW   = $clog2(N_CUBES);
  localparam logic [AW-1:0] LAST = AW'(N_CUBES - 1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [N_IN-1:0]  x_q;
  logic [N_OUT-1:0] acc;
  logic [N_OUT-1:0] acc_next;
  logic             rd_en;
  logic [N_IN-1:0]  rd_care;
  logic [N_IN-1:0]  rd_val;
  logic [N_OUT-1:0] rd_out;
  logic             hit;
  logic             table_we;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the source holds its payload until then, and out_y stays frozen while out_valid waits.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign table_we = cfg_we && (state == IDLE);

  pla_cube_table #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .N_CUBES (N_CUBES),
    .AW      (AW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (table_we),
    .waddr   (cfg_addr),
    .wr_en   (cfg_en),
    .wr_care (cfg_care),
    .wr_val  (cfg_val),
    .wr_out  (cfg_out),
    .raddr   (idx),
    .rd_en   (rd_en),
    .rd_care (rd_care),
    .rd_val  (rd_val),
    .rd_out  (rd_out)
  );

  assign hit      = rd_en && cube_match(MAX_IN'(x_q), MAX_IN'(rd_care), MAX_IN'(rd_val));
  assign acc_next = acc | (hit ? rd_out : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      x_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_y     <= OUT_INV;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_x;
            idx   <= '0;
            acc   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (idx == LAST || acc_next == '1) begin
            out_y     <= acc_next ^ OUT_INV;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_seq_evaluator.sv
// Randomised scoreboard bench for pla_seq_evaluator against a cube-table reference model.
module tb_pla_seq_evaluator;

  localparam int               N_IN    = 21;
  localparam int               N_OUT   = 2;
  localparam int               N_CUBES = 4;
  localparam logic [N_OUT-1:0] OUT_INV = 2'b10;
  localparam int               AW      = $clog2(N_CUBES);
  localparam int               W       = 8 + N_OUT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic             cfg_en = 1'b0;
  logic [N_IN-1:0]  cfg_care = '0;
  logic [N_IN-1:0]  cfg_val = '0;
  logic [N_OUT-1:0] cfg_out = '0;
  logic             cfg_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_x = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_OUT-1:0] out_y;
  logic             busy;

  pla_seq_evaluator #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_CUBES(N_CUBES), .OUT_INV(OUT_INV)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [W-1:0] exp_q[$];

  // reference cube table
  logic             m_en   [N_CUBES];
  logic [N_IN-1:0]  m_care [N_CUBES];
  logic [N_IN-1:0]  m_val  [N_CUBES];
  logic [N_OUT-1:0] m_out  [N_CUBES];

  // staged write used by run_eval when a write shares the accept cycle
  int               co_addr;
  logic             co_en;
  logic [N_IN-1:0]  co_care;
  logic [N_IN-1:0]  co_val;
  logic [N_OUT-1:0] co_out;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {latency, out_y}: OR of matching cube outputs, stop at the cube that fills every output.
  function automatic logic [W-1:0] model(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] y;
    int last;
    y = '0;
    last = N_CUBES - 1;
    for (int i = 0; i < N_CUBES; i++) begin
      if (m_en[i] && ((x & m_care[i]) == (m_val[i] & m_care[i]))) y = y | m_out[i];
      if (y == {N_OUT{1'b1}}) begin
        last = i;
        break;
      end
    end
    return {8'(last + 1), y ^ OUT_INV};
  endfunction

  // monitor / scoreboard
  logic             prev_ov = 1'b0;
  logic [N_OUT-1:0] held = '0;
  logic [W-1:0]     e;
  initial forever begin
    @(negedge clk);
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_y=%0h with nothing expected", out_y);
      end else begin
        e = exp_q.pop_front();
        check("out_y", 32'(out_y), 32'(e[N_OUT-1:0]));
        check("latency", 32'(cyc - accept_cyc), 32'(e[W-1:N_OUT]));
      end
      held = out_y;
    end else if (out_valid && prev_ov) begin
      check("hold_out_y_stable", 32'(out_y), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_busy", 32'(busy), 32'(1));
    end
    prev_ov = out_valid;
  end

  task automatic cfg_write(input int a, input logic en, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] val, input logic [N_OUT-1:0] o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_en = en; cfg_care = care; cfg_val = val; cfg_out = o;
    m_en[a] = en; m_care[a] = care; m_val[a] = val; m_out[a] = o;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle_write", 32'(cfg_err), 32'(0));
  endtask

  task automatic run_eval(input logic [N_IN-1:0] x, input int hold, input bit bad_write,
                          input bit co_write);
    int n;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'(1));
    if (co_write) begin
      cfg_we = 1'b1; cfg_addr = AW'(co_addr); cfg_en = co_en;
      cfg_care = co_care; cfg_val = co_val; cfg_out = co_out;
      m_en[co_addr] = co_en; m_care[co_addr] = co_care;
      m_val[co_addr] = co_val; m_out[co_addr] = co_out;
    end
    exp_q.push_back(model(x));
    in_valid = 1'b1;
    in_x = x;
    @(negedge clk);
    accept_cyc = cyc;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    in_x = N_IN'($urandom);
    check("after_accept_busy", 32'(busy), 32'(1));
    check("after_accept_in_ready", 32'(in_ready), 32'(0));
    if (co_write) check("cfg_err_co_write", 32'(cfg_err), 32'(0));
    if (bad_write) begin
      cfg_we = 1'b1; cfg_addr = AW'(2); cfg_en = 1'b1;
      cfg_care = '0; cfg_val = N_IN'($urandom); cfg_out = '1;
      @(negedge clk);
      cfg_we = 1'b0;
      check("cfg_err_pulse", 32'(cfg_err), 32'(1));
      @(negedge clk);
      check("cfg_err_clear", 32'(cfg_err), 32'(0));
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles, expected a result", n);
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'(0));
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_busy", 32'(busy), 32'(0));
  endtask

  task automatic reset_mid_scan(input logic [N_IN-1:0] x);
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_scan_busy", 32'(busy), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_y", 32'(out_y), 32'(OUT_INV));
    for (int i = 0; i < N_CUBES; i++) m_en[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN-1:0] x;
    int a;
    for (int i = 0; i < N_CUBES; i++) begin
      m_en[i] = 1'b0; m_care[i] = '0; m_val[i] = '0; m_out[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out_y", 32'(out_y), 32'(OUT_INV));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_cfg_err", 32'(cfg_err), 32'(0));
    rst = 1'b0;

    // empty table: full scan, no match
    run_eval(21'h1FFFFF, 0, 1'b0, 1'b0);
    // fully specified cube driving both outputs: early exit on cube 0
    cfg_write(0, 1'b1, 21'h1FFFFF, 21'h15555, 2'b11);
    run_eval(21'h15555, 1, 1'b0, 1'b0);
    run_eval(21'h15554, 0, 1'b0, 1'b0);
    // two partial cubes combine to all-ones on the last cube
    cfg_write(0, 1'b0, 21'h1FFFFF, 21'h15555, 2'b11);
    cfg_write(1, 1'b1, 21'h000001, 21'h000001, 2'b01);
    cfg_write(3, 1'b1, 21'h000000, 21'h000000, 2'b10);
    run_eval(21'h000003, 5, 1'b0, 1'b0);
    run_eval(21'h000002, 2, 1'b0, 1'b0);
    // dropped write while busy
    run_eval(21'h000003, 0, 1'b1, 1'b0);
    run_eval(21'h000000, 0, 1'b0, 1'b0);
    // write in the accept cycle is seen by that request
    co_addr = 0; co_en = 1'b1; co_care = '0; co_val = '0; co_out = 2'b11;
    run_eval(21'h0ABCDE, 0, 1'b0, 1'b1);
    // reset during a scan invalidates the table
    cfg_write(0, 1'b1, 21'h1FFFFF, 21'h0AAAA, 2'b11);
    run_eval(21'h0AAAA, 0, 1'b0, 1'b0);
    reset_mid_scan(21'h000000);
    run_eval(21'h0AAAA, 0, 1'b0, 1'b0);

    // randomised table updates and requests
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, N_CUBES - 1);
        cfg_write(a, $urandom_range(0, 3) != 0,
                  N_IN'($urandom) & N_IN'($urandom) & N_IN'($urandom) & N_IN'($urandom),
                  N_IN'($urandom), N_OUT'($urandom));
      end
      a = $urandom_range(0, N_CUBES - 1);
      x = ($urandom_range(0, 1) == 1) ? (m_val[a] ^ (N_IN'(1) << $urandom_range(0, N_IN - 1)))
                                      : N_IN'($urandom);
      if ($urandom_range(0, 2) == 0) x = m_val[a];
      if ($urandom_range(0, 7) == 0) begin
        co_addr = $urandom_range(0, N_CUBES - 1);
        co_en = $urandom_range(0, 1) == 1;
        co_care = N_IN'($urandom) & N_IN'($urandom);
        co_val = N_IN'($urandom);
        co_out = N_OUT'($urandom);
        run_eval(x, $urandom_range(0, 3), 1'b0, 1'b1);
      end else begin
        run_eval(x, $urandom_range(0, 3), $urandom_range(0, 5) == 0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expected: %0d results never produced", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
